// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding,
// RV32I width codes and the wait-counter width.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } lsu_state_e;

    localparam int CNT_W = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Width codes that are not legal for the given direction.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: f3_illegal = 1'b0;
            F3_BU, F3_HU:     f3_illegal = we;
            default:          f3_illegal = 1'b1;
        endcase
    endfunction

    // Halfword on an odd byte, or word off a word boundary.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3)
            F3_H, F3_HU: f3_misaligned = addr_lo[0];
            F3_W:        f3_misaligned = (addr_lo != 2'b00);
            default:     f3_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane handling for the LSU: write strobes, store-data replication
// and load-data extraction with sign/zero extension. Purely combinational.
// Halfwords are placed by addr[1] only and words always use the whole
// aligned word, so misaligned accesses degrade gracefully when not trapped.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  strobe,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Select the addressed byte and halfword out of the read word.
    always_comb begin
        case (addr_lo)
            2'b00:   rbyte = rdata[7:0];
            2'b01:   rbyte = rdata[15:8];
            2'b10:   rbyte = rdata[23:16];
            default: rbyte = rdata[31:24];
        endcase
        rhalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Per-width lane strobes, replicated store data and extended load data.
    always_comb begin
        strobe    = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = 32'h0;
        case (funct3)
            F3_B, F3_BU: begin
                strobe    = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = (funct3 == F3_B) ? {{24{rbyte[7]}}, rbyte} : {24'h0, rbyte};
            end
            F3_H, F3_HU: begin
                strobe    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = (funct3 == F3_H) ? {{16{rhalf[15]}}, rhalf} : {16'h0, rhalf};
            end
            F3_W: begin
                strobe    = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
            default: begin
                strobe    = 4'b0000;
                wdata_rep = wdata;
                rdata_ext = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single-outstanding request FSM between core and data memory.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned H/HU/W return an
// access fault without touching memory).
//
// state | meaning
// IDLE  | ready for a request, memory address bus held at 0
// WAIT  | memory access in flight; loads count down LATENCY cycles, stores
//       | spend exactly one cycle here (counter 0) driving the write strobes
// RESP  | one-cycle response pulse, then back to IDLE
module lsu
    import lsu_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [2:0]       f3_q;

    logic             fault;
    logic [3:0]       strobe;
    logic [31:0]      wdata_rep;
    logic [31:0]      rdata_ext;

`ifdef LSU_MISALIGN_TRAP_EN
    assign fault = f3_illegal(req_we, req_funct3) | f3_misaligned(req_funct3, req_addr[1:0]);
`else
    assign fault = f3_illegal(req_we, req_funct3);
`endif

    lsu_align u_align (
        .funct3    (f3_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (mem_rdata),
        .strobe    (strobe),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    // Only legal stores ever reach WAIT with we_q set, so the strobe is
    // live for exactly that single cycle.
    assign req_ready = (state == IDLE);
    assign mem_addr  = (state != IDLE) ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_we    = (state == WAIT && we_q) ? strobe : 4'b0000;
    assign mem_wdata = wdata_rep;

    // Request FSM with registered response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            f3_q       <= 3'b000;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        f3_q    <= req_funct3;
                        if (fault) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= req_we ? '0 : CNT_W'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= we_q ? 32'h0 : rdata_ext;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: the driver pushes the expected response (and
// the cycle it is due) into a queue; an independent monitor pops and
// compares whenever resp_valid is seen.
module tb_lsu;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem_word;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    assign mem_rdata = mem_word;

    lsu #(.LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_err",   {31'h0, resp_err}, {31'h0, e.err});
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_cycle", cyc, e.due);
            end
        end
    end

    // Issue one request at a negedge and check the memory-side cycles.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, input logic [31:0] mem_val,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wd,
                          input logic exp_err, input logic [31:0] exp_rd, input int lat,
                          output int acc_cyc);
        int guard;
        exp_t e;
        mem_word = mem_val;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        acc_cyc = cyc;
        if (req_ready !== 1'b1) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        e.err   = exp_err;
        e.rdata = exp_rd;
        e.due   = cyc + lat;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = ~we;
        req_addr   = ~addr;
        req_wdata  = ~wdata;
        req_funct3 = 3'b111;
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            chk("mem_we", {28'h0, mem_we}, {28'h0, (i == 1) ? exp_strb : 4'b0000});
            chk("req_ready_busy", {31'h0, req_ready}, 32'd0);
            if (i == 1) chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
            if (i == 1 && exp_strb != 4'b0000) chk("mem_wdata", mem_wdata, exp_wd);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_funct3 = 3'b000;
        mem_word   = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready",  {31'h0, req_ready}, 32'd1);
        chk("rst_valid",  {31'h0, resp_valid}, 32'd0);
        chk("rst_mem_we", {28'h0, mem_we}, 32'd0);
        chk("rst_addr",   mem_addr, 32'h0);
        chk("rst_rdata",  resp_rdata, 32'h0);
        reset = 1'b0;

        // stores
        do_req(1, 32'h100, 32'hDEADBEEF, 3'b010, 32'h0, 4'b1111, 32'hDEADBEEF, 0, 32'h0, 2, a0);
        do_req(1, 32'h103, 32'h000000A5, 3'b000, 32'h0, 4'b1000, 32'hA5A5A5A5, 0, 32'h0, 2, a0);
        do_req(1, 32'h102, 32'h00001234, 3'b001, 32'h0, 4'b1100, 32'h12341234, 0, 32'h0, 2, a0);
        do_req(1, 32'h101, 32'h000000C3, 3'b000, 32'h0, 4'b0010, 32'hC3C3C3C3, 0, 32'h0, 2, a0);

        // loads
        do_req(0, 32'h102, 32'h0, 3'b000, 32'h1280FF34, 4'b0000, 32'h0, 0, 32'hFFFFFF80, LAT + 1, a0);
        do_req(0, 32'h102, 32'h0, 3'b100, 32'h1280FF34, 4'b0000, 32'h0, 0, 32'h00000080, LAT + 1, a0);
        do_req(0, 32'h102, 32'h0, 3'b001, 32'h1280FF34, 4'b0000, 32'h0, 0, 32'h00001280, LAT + 1, a0);
        do_req(0, 32'h100, 32'h0, 3'b001, 32'h1280FF34, 4'b0000, 32'h0, 0, 32'hFFFFFF34, LAT + 1, a0);
        do_req(0, 32'h100, 32'h0, 3'b101, 32'h1280FF34, 4'b0000, 32'h0, 0, 32'h0000FF34, LAT + 1, a0);
        do_req(0, 32'h104, 32'h0, 3'b010, 32'h89ABCDEF, 4'b0000, 32'h0, 0, 32'h89ABCDEF, LAT + 1, a0);

        // illegal width codes
        do_req(0, 32'h100, 32'h0, 3'b011, 32'h12345678, 4'b0000, 32'h0, 1, 32'h0, 1, a0);
        do_req(1, 32'h100, 32'h55, 3'b100, 32'h0, 4'b0000, 32'h0, 1, 32'h0, 1, a0);

        // misaligned accesses
`ifdef LSU_MISALIGN_TRAP_EN
        do_req(0, 32'h101, 32'h0, 3'b001, 32'h1280FF34, 4'b0000, 32'h0, 1, 32'h0, 1, a0);
        do_req(1, 32'h102, 32'hCAFEF00D, 3'b010, 32'h0, 4'b0000, 32'h0, 1, 32'h0, 1, a0);
`else
        do_req(0, 32'h101, 32'h0, 3'b001, 32'h1280FF34, 4'b0000, 32'h0, 0, 32'hFFFFFF34, LAT + 1, a0);
        do_req(1, 32'h102, 32'hCAFEF00D, 3'b010, 32'h0, 4'b1111, 32'hCAFEF00D, 0, 32'h0, 2, a0);
`endif

        // back-to-back turnaround
        do_req(1, 32'h200, 32'h11223344, 3'b010, 32'h0, 4'b1111, 32'h11223344, 0, 32'h0, 2, a0);
        do_req(0, 32'h200, 32'h0, 3'b010, 32'h11223344, 4'b0000, 32'h0, 0, 32'h11223344, LAT + 1, a1);
        chk("store_turnaround", a1 - a0, 32'd3);
        do_req(1, 32'h204, 32'h0000BEEF, 3'b001, 32'h0, 4'b0011, 32'hBEEFBEEF, 0, 32'h0, 2, a0);
        chk("load_turnaround", a0 - a1, LAT + 2);

        // reset during WAIT aborts the load
        @(negedge clk);
        @(negedge clk);
        mem_word   = 32'hFFFFFFFF;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 32'h300;
        req_funct3 = 3'b010;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_valid",  {31'h0, resp_valid}, 32'd0);
        chk("abort_mem_we", {28'h0, mem_we}, 32'd0);
        chk("abort_addr",   mem_addr, 32'h0);
        chk("abort_err",    {31'h0, resp_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ready_after_release", {31'h0, req_ready}, 32'd1);
        @(negedge clk);
        a1 = cyc;
        do_req(0, 32'h304, 32'h0, 3'b010, 32'h0BADF00D, 4'b0000, 32'h0, 0, 32'h0BADF00D, LAT + 1, a0);
        chk("accept_after_release", a0, a1);

        repeat (6) @(negedge clk);
        chk("responses_outstanding", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
